burst_pixel_packer: RTL and testbench

BURST_PIXEL_PACKER -- requirements
Module: burst_pixel_packer

---
 rtl/burst_pixel_packer.sv | 172 +++++++++++++++++
 tb/tb_burst_pixel_packer.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_pixel_packer.sv
// burst_pixel_packer: unpacks framed UART pixel packets into 32-bit R/G/B SRAM words.
// Ports: clk, i_rst_n; burst command i_burst_start/i_height/i_width; byte stream i_byte_valid/i_byte;
//        SRAM write o_we/o_addr/o_wdata_r/g/b (one shared strobe); status o_busy, o_done, o_err pulses.
module burst_pixel_packer #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_burst_start,
  input  logic [11:0]       i_height,
  input  logic [11:0]       i_width,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [31:0]       o_wdata_r,
  output logic [31:0]       o_wdata_g,
  output logic [31:0]       o_wdata_b,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_OPEN, S_PAYLOAD, S_WRITE, S_DONE} state_t;

  localparam logic [7:0] OPEN  = 8'h7B;
  localparam logic [7:0] COMMA = 8'h2C;
  localparam logic [7:0] CLOSE = 8'h7D;

  // payload channel select follows byte order R, B, G within each pixel
  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_G = 2'd2;

  state_t      state;
  logic [3:0]  pos;          // position of the next expected byte after '{' (1..15)
  logic [21:0] total_words;
  logic [21:0] word_cnt;
  logic [21:0] cnt_inc;
  logic [21:0] total_calc;
  logic [23:0] area;
  logic [31:0] buf_r, buf_g, buf_b;  // packet under assembly; only copied out on a clean '}'
  logic        is_delim;
  logic [7:0]  delim_byte;
  logic [1:0]  pix;
  logic [1:0]  ch;

  // ceil(pixels / 4) without a 25-bit adder: drop the low bits and round up if any were set
  assign area       = {12'd0, i_height} * {12'd0, i_width};
  assign total_calc = area[23:2] + {21'd0, |area[1:0]};
  assign cnt_inc    = word_cnt + 22'd1;

  // decode packet position into delimiter check or payload lane
  always_comb begin
    is_delim   = 1'b0;
    delim_byte = COMMA;
    pix        = 2'd0;
    ch         = CH_R;
    case (pos)
      4'd5, 4'd10: is_delim = 1'b1;
      4'd15: begin is_delim = 1'b1; delim_byte = CLOSE; end
      4'd1:  begin pix = 2'd0; ch = CH_R; end
      4'd2:  begin pix = 2'd0; ch = CH_B; end
      4'd3:  begin pix = 2'd0; ch = CH_G; end
      4'd4:  begin pix = 2'd1; ch = CH_R; end
      4'd6:  begin pix = 2'd1; ch = CH_B; end
      4'd7:  begin pix = 2'd1; ch = CH_G; end
      4'd8:  begin pix = 2'd2; ch = CH_R; end
      4'd9:  begin pix = 2'd2; ch = CH_B; end
      4'd11: begin pix = 2'd2; ch = CH_G; end
      4'd12: begin pix = 2'd3; ch = CH_R; end
      4'd13: begin pix = 2'd3; ch = CH_B; end
      4'd14: begin pix = 2'd3; ch = CH_G; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      pos         <= 4'd0;
      total_words <= 22'd0;
      word_cnt    <= 22'd0;
      o_addr      <= '0;
      o_we        <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_wdata_r   <= 32'd0;
      o_wdata_g   <= 32'd0;
      o_wdata_b   <= 32'd0;
      buf_r       <= 32'd0;
      buf_g       <= 32'd0;
      buf_b       <= 32'd0;
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (i_burst_start) begin
        // restart wins over everything, including a byte arriving this cycle
        total_words <= total_calc;
        o_addr      <= '0;
        word_cnt    <= 22'd0;
        pos         <= 4'd0;
        if (total_calc == 22'd0) begin
          state  <= S_DONE;
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end else begin
          state  <= S_WAIT_OPEN;
          o_busy <= 1'b1;
        end
      end else begin
        case (state)
          S_IDLE: ;
          S_WAIT_OPEN: begin
            if (i_byte_valid && i_byte == OPEN) begin
              state <= S_PAYLOAD;
              pos   <= 4'd1;
            end
          end
          S_PAYLOAD: begin
            if (i_byte_valid) begin
              if (is_delim) begin
                if (i_byte != delim_byte) begin
                  o_err <= 1'b1;
                  state <= S_WAIT_OPEN;
                end else if (pos == 4'd15) begin
                  state     <= S_WRITE;
                  o_we      <= 1'b1;
                  o_wdata_r <= buf_r;
                  o_wdata_g <= buf_g;
                  o_wdata_b <= buf_b;
                end else begin
                  pos <= pos + 4'd1;
                end
              end else begin
                case (ch)
                  CH_R:    buf_r[{pix, 3'b000} +: 8] <= i_byte;
                  CH_B:    buf_b[{pix, 3'b000} +: 8] <= i_byte;
                  default: buf_g[{pix, 3'b000} +: 8] <= i_byte;
                endcase
                pos <= pos + 4'd1;
              end
            end
          end
          S_WRITE: begin
            // o_we is high during this cycle; address moves on once it has been seen
            o_addr   <= o_addr + ADDR_W'(1);
            word_cnt <= cnt_inc;
            if (cnt_inc == total_words) begin
              state  <= S_DONE;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else if (i_byte_valid && i_byte == OPEN) begin
              state <= S_PAYLOAD;
              pos   <= 4'd1;
            end else begin
              state <= S_WAIT_OPEN;
            end
          end
          S_DONE: state <= S_IDLE;
          default: begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_burst_pixel_packer.sv
// tb_burst_pixel_packer: self-checking bench for burst_pixel_packer.
// Directed hand sequences, a table of burst vectors and randomized bursts against a
// stream-level packet parser model.
module tb_burst_pixel_packer;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              i_rst_n;
  logic              i_burst_start;
  logic [11:0]       i_height, i_width;
  logic              i_byte_valid;
  logic [7:0]        i_byte;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [31:0]       o_wdata_r, o_wdata_g, o_wdata_b;
  logic              o_busy, o_done, o_err;

  always #5 clk = ~clk;

  burst_pixel_packer #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_burst_start(i_burst_start),
    .i_height(i_height), .i_width(i_width),
    .i_byte_valid(i_byte_valid), .i_byte(i_byte),
    .o_we(o_we), .o_addr(o_addr),
    .o_wdata_r(o_wdata_r), .o_wdata_g(o_wdata_g), .o_wdata_b(o_wdata_b),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  typedef struct {
    logic [15:0] addr;
    logic [31:0] r, g, b;
  } wr_t;

  typedef struct {
    int h; int w; int npk; int bad_pos; logic [7:0] bad_val;
    int exp_wr; int exp_err; int exp_done;
  } vec_t;

  wr_t        wq[$];
  wr_t        exp_q[$];
  wr_t        mon_w;
  int         mon_err = 0, mon_done = 0;
  int         exp_errs, exp_done;
  logic [7:0] stim[$];
  logic [7:0] pkt31[16];
  vec_t       tbl[10];
  int         n_cmp = 0, n_bad = 0;

  // observe outputs away from the rising edge
  always @(negedge clk) begin
    if (o_we === 1'b1) begin
      mon_w.addr = o_addr; mon_w.r = o_wdata_r; mon_w.g = o_wdata_g; mon_w.b = o_wdata_b;
      wq.push_back(mon_w);
    end
    if (o_err === 1'b1) mon_err++;
    if (o_done === 1'b1) mon_done++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_byte_valid = 1'b1; i_byte = b;
    cycle();
    i_byte_valid = 1'b0;
  endtask

  task automatic start_burst(input int h, input int w);
    i_height = 12'(h); i_width = 12'(w); i_burst_start = 1'b1;
    cycle();
    i_burst_start = 1'b0;
  endtask

  task automatic clear_mon();
    wq.delete(); mon_err = 0; mon_done = 0;
  endtask

  task automatic load31();
    stim.delete();
    foreach (pkt31[i]) stim.push_back(pkt31[i]);
  endtask

  // one framed packet; payload bytes never equal '{' so table counts stay predictable
  task automatic add_packet(input int bad_pos, input logic [7:0] bad_val);
    logic [7:0] b;
    stim.push_back(8'h7B);
    for (int p = 1; p <= 15; p++) begin
      if (p == bad_pos) b = bad_val;
      else if (p == 5 || p == 10) b = 8'h2C;
      else if (p == 15) b = 8'h7D;
      else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h7B) b = 8'h00;
      end
      stim.push_back(b);
    end
  endtask

  task automatic feed(input bit gaps);
    int unsigned g;
    foreach (stim[i]) begin
      if (gaps) begin
        g = $urandom_range(0, 2);
        repeat (g) begin i_byte = 8'($urandom); cycle(); end
      end
      send_byte(stim[i]);
    end
  endtask

  // parses the byte stream as framed packets and lists the words that must be written
  task automatic run_model(input int h, input int w);
    int total, n, i, kk;
    bit ok, trunc;
    logic [7:0] b;
    logic [7:0] pl[12];
    wr_t e;
    exp_q.delete(); exp_errs = 0;
    total = (h * w + 3) / 4;
    n = 0; i = 0; trunc = 1'b0;
    while (total > 0 && n < total && i < stim.size() && !trunc) begin
      b = stim[i]; i++;
      if (b == 8'h7B) begin
        ok = 1'b1; kk = 0;
        for (int p = 1; p <= 15 && ok && !trunc; p++) begin
          if (i >= stim.size()) trunc = 1'b1;
          else begin
            b = stim[i]; i++;
            if (p == 5 || p == 10) begin
              if (b != 8'h2C) begin ok = 1'b0; exp_errs++; end
            end else if (p == 15) begin
              if (b != 8'h7D) begin ok = 1'b0; exp_errs++; end
            end else begin
              pl[kk] = b; kk++;
            end
          end
        end
        if (ok && !trunc) begin
          e.r = 32'd0; e.g = 32'd0; e.b = 32'd0;
          for (int k = 0; k < 12; k++) begin
            case (k % 3)
              0:       e.r[8*(k/3) +: 8] = pl[k];
              1:       e.b[8*(k/3) +: 8] = pl[k];
              default: e.g[8*(k/3) +: 8] = pl[k];
            endcase
          end
          e.addr = 16'(n);
          exp_q.push_back(e);
          n++;
        end
      end
    end
    exp_done = (n == total) ? 1 : 0;
  endtask

  task automatic run_burst(input string tag, input int h, input int w, input bit gaps);
    int m;
    run_model(h, w);
    clear_mon();
    start_burst(h, w);
    feed(gaps);
    repeat (4) cycle();
    check({tag, " n_writes"}, 64'(wq.size()), 64'(exp_q.size()));
    m = (wq.size() < exp_q.size()) ? wq.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      check({tag, " addr"}, 64'(wq[i].addr), 64'(exp_q[i].addr));
      check({tag, " r"}, 64'(wq[i].r), 64'(exp_q[i].r));
      check({tag, " g"}, 64'(wq[i].g), 64'(exp_q[i].g));
      check({tag, " b"}, 64'(wq[i].b), 64'(exp_q[i].b));
    end
    check({tag, " errs"}, 64'(mon_err), 64'(exp_errs));
    check({tag, " dones"}, 64'(mon_done), 64'(exp_done));
    check({tag, " busy"}, 64'(o_busy), 64'(exp_done == 0));
  endtask

  initial begin
    int unsigned h, w, total, bp, junk;
    pkt31 = '{8'h7B, 8'h10, 8'h30, 8'h20, 8'h11, 8'h2C, 8'h31, 8'h21,
              8'h12, 8'h32, 8'h2C, 8'h22, 8'h13, 8'h33, 8'h23, 8'h7D};
    //          h     w  npk bad  badval  wr err done
    tbl[0] = '{1,    4, 1, 0,  8'h00, 1, 0, 1};
    tbl[1] = '{2,    4, 2, 0,  8'h00, 2, 0, 1};
    tbl[2] = '{1,    4, 2, 5,  8'h2D, 1, 1, 1};
    tbl[3] = '{0,    5, 1, 0,  8'h00, 0, 0, 1};
    tbl[4] = '{3,    3, 3, 0,  8'h00, 3, 0, 1};
    tbl[5] = '{1,    5, 1, 0,  8'h00, 1, 0, 0};
    tbl[6] = '{1,    4, 2, 15, 8'h7C, 1, 1, 1};
    tbl[7] = '{2,    2, 3, 10, 8'h00, 1, 1, 1};
    tbl[8] = '{4095, 0, 1, 0,  8'h00, 0, 0, 1};
    tbl[9] = '{1,    1, 1, 0,  8'h00, 1, 0, 1};

    i_rst_n = 1'b0; i_burst_start = 1'b0; i_height = 12'd0; i_width = 12'd0;
    i_byte_valid = 1'b0; i_byte = 8'h00;
    cycle(); cycle();
    check("rst we", 64'(o_we), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    check("rst done", 64'(o_done), 64'd0);
    check("rst err", 64'(o_err), 64'd0);
    check("rst addr", 64'(o_addr), 64'd0);
    check("rst wdata", {o_wdata_r, o_wdata_g}, 64'd0);
    i_rst_n = 1'b1;
    cycle();

    // single packet: exact write timing and lane packing
    clear_mon();
    start_burst(1, 4);
    check("s1 busy", 64'(o_busy), 64'd1);
    foreach (pkt31[i]) send_byte(pkt31[i]);
    check("s1 we", 64'(o_we), 64'd1);
    check("s1 addr", 64'(o_addr), 64'd0);
    check("s1 r", 64'(o_wdata_r), 64'h13121110);
    check("s1 g", 64'(o_wdata_g), 64'h23222120);
    check("s1 b", 64'(o_wdata_b), 64'h33323130);
    cycle();
    check("s1 we after", 64'(o_we), 64'd0);
    check("s1 done", 64'(o_done), 64'd1);
    check("s1 busy low", 64'(o_busy), 64'd0);
    check("s1 addr inc", 64'(o_addr), 64'd1);
    cycle();
    check("s1 done pulse", 64'(o_done), 64'd0);
    check("s1 n_writes", 64'(wq.size()), 64'd1);

    // table of bursts: counts from the table, data from the model
    for (int t = 0; t < 10; t++) begin
      stim.delete();
      for (int j = 0; j < tbl[t].npk; j++)
        add_packet((j == 0) ? tbl[t].bad_pos : 0, tbl[t].bad_val);
      run_burst($sformatf("tbl%0d", t), tbl[t].h, tbl[t].w, 1'b0);
      check($sformatf("tbl%0d wr", t), 64'(wq.size()), 64'(tbl[t].exp_wr));
      check($sformatf("tbl%0d err", t), 64'(mon_err), 64'(tbl[t].exp_err));
      check($sformatf("tbl%0d done", t), 64'(mon_done), 64'(tbl[t].exp_done));
    end

    // empty image: done one cycle after start, later bytes ignored
    clear_mon();
    start_burst(0, 5);
    check("zero done", 64'(o_done), 64'd1);
    check("zero busy", 64'(o_busy), 64'd0);
    cycle();
    check("zero done pulse", 64'(o_done), 64'd0);
    load31(); feed(1'b0); repeat (3) cycle();
    check("zero n_writes", 64'(wq.size()), 64'd0);
    check("zero dones", 64'(mon_done), 64'd1);

    // restart mid-packet; the '{' sharing the start cycle must be dropped
    clear_mon();
    start_burst(1, 4);
    for (int i = 0; i < 7; i++) send_byte(pkt31[i]);
    i_burst_start = 1'b1; i_byte_valid = 1'b1; i_byte = 8'h7B;
    cycle();
    i_burst_start = 1'b0; i_byte_valid = 1'b0;
    for (int i = 1; i < 16; i++) send_byte(pkt31[i]);
    check("restart no write", 64'(wq.size()), 64'd0);
    load31(); feed(1'b0); repeat (3) cycle();
    check("restart n_writes", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) check("restart addr", 64'(wq[0].addr), 64'd0);
    check("restart errs", 64'(mon_err), 64'd0);
    check("restart dones", 64'(mon_done), 64'd1);

    // reset mid-packet
    clear_mon();
    start_burst(1, 4);
    for (int i = 0; i < 9; i++) send_byte(pkt31[i]);
    i_rst_n = 1'b0;
    cycle();
    check("mrst we", 64'(o_we), 64'd0);
    check("mrst busy", 64'(o_busy), 64'd0);
    check("mrst flags", {62'd0, o_done, o_err}, 64'd0);
    check("mrst addr", 64'(o_addr), 64'd0);
    check("mrst wdata rg", {o_wdata_r, o_wdata_g}, 64'd0);
    check("mrst wdata b", 64'(o_wdata_b), 64'd0);
    i_rst_n = 1'b1;
    for (int i = 9; i < 16; i++) send_byte(pkt31[i]);
    load31(); feed(1'b0); repeat (3) cycle();
    check("mrst n_writes", 64'(wq.size()), 64'd0);
    check("mrst busy idle", 64'(o_busy), 64'd0);

    // data and address hold across a rejected packet
    clear_mon();
    start_burst(1, 8);
    load31(); feed(1'b0); repeat (2) cycle();
    stim.delete(); add_packet(10, 8'h00); feed(1'b0); repeat (3) cycle();
    check("hold errs", 64'(mon_err), 64'd1);
    check("hold n_writes", 64'(wq.size()), 64'd1);
    check("hold addr", 64'(o_addr), 64'd1);
    check("hold r", 64'(o_wdata_r), 64'h13121110);
    check("hold g", 64'(o_wdata_g), 64'h23222120);
    check("hold b", 64'(o_wdata_b), 64'h33323130);
    check("hold busy", 64'(o_busy), 64'd1);

    // randomized bursts with junk, corrupted delimiters and idle gaps
    for (int it = 0; it < 25; it++) begin
      h = $urandom_range(0, 3);
      w = $urandom_range(0, 6);
      total = (h * w + 3) / 4;
      stim.delete();
      for (int j = 0; j < int'(total) + 2; j++) begin
        junk = $urandom_range(0, 2);
        repeat (junk) stim.push_back(8'($urandom));
        bp = 0;
        if ($urandom_range(0, 4) == 0) begin
          case ($urandom_range(0, 2))
            0:       bp = 5;
            1:       bp = 10;
            default: bp = 15;
          endcase
        end
        add_packet(int'(bp), 8'($urandom));
      end
      run_burst($sformatf("rnd%0d", it), int'(h), int'(w), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
